// File: rtl/data_mem_responder.sv
// Load/store responder: word-organised data RAM behind a request/response handshake with WAIT_CYCLES wait states.
// Optional macro DMEM_STORE_ACK_EN: when defined, stores also produce a response (including error status).
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

`ifdef DMEM_STORE_ACK_EN
  localparam bit STORE_ACK = 1'b1;
`else
  localparam bit STORE_ACK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic          we_reg;
  logic [2:0]    funct3_reg;
  logic [31:0]   addr_reg, wdata_reg;
  logic          err_reg;
  logic          load_ok_reg;

  logic          accept, req_err, do_access;
  logic          a_we;
  logic [2:0]    a_funct3;
  logic [31:0]   a_addr, a_wdata;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wdata_al;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   ram_q;

  function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
    logic bad_f3, misal, oor;
    if (we) bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010});
    else    bad_f3 = !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misal = ((f3[1:0] == 2'b01) && addr[0]) || ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    oor   = (addr >> (AW + 2)) != 32'd0;
    return bad_f3 | misal | oor;
  endfunction

  assign req_ready = (state_reg == IDLE) && !rst;
  assign rsp_valid = (state_reg == RESP);
  assign accept    = (state_reg == IDLE) && req_valid;
  assign req_err   = access_err(req_we, req_funct3, req_addr);

  // With zero wait states the access uses the live request, otherwise the captured copy.
  assign a_we     = (state_reg == IDLE) ? req_we     : we_reg;
  assign a_funct3 = (state_reg == IDLE) ? req_funct3 : funct3_reg;
  assign a_addr   = (state_reg == IDLE) ? req_addr   : addr_reg;
  assign a_wdata  = (state_reg == IDLE) ? req_wdata  : wdata_reg;
  assign idx      = a_addr[AW+1:2];

  assign do_access = (accept && !req_err && (WAIT_CYCLES == 0)) ||
                     ((state_reg == WAIT) && (cnt_reg == 4'd0));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          if (req_err || (WAIT_CYCLES == 0)) begin
            state_next = (req_we && !STORE_ACK) ? IDLE : RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) state_next = (we_reg && !STORE_ACK) ? IDLE : RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= 4'd0;
      err_reg     <= 1'b0;
      load_ok_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg      <= req_we;
        funct3_reg  <= req_funct3;
        addr_reg    <= req_addr;
        wdata_reg   <= req_wdata;
        err_reg     <= req_err;
        load_ok_reg <= 1'b0;
      end
      if (do_access && !a_we) load_ok_reg <= 1'b1;
    end
  end

  // Byte enables and lane-replicated store data.
  always_comb begin
    be       = 4'b1111;
    wdata_al = a_wdata;
    case (a_funct3[1:0])
      2'b00: begin
        be       = 4'b0001 << a_addr[1:0];
        wdata_al = {4{a_wdata[7:0]}};
      end
      2'b01: begin
        be       = a_addr[1] ? 4'b1100 : 4'b0011;
        wdata_al = {2{a_wdata[15:0]}};
      end
      default: begin
        be       = 4'b1111;
        wdata_al = a_wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && do_access) begin
      if (a_we) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][b*8 +: 8] <= wdata_al[b*8 +: 8];
        end
      end else begin
        ram_q <= mem[idx];
      end
    end
  end

  // Extension works off the registered word and the captured request, so it stays stable in RESP.
  logic [7:0]  lane_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] ext_data;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_byte[gi] = ram_q[gi*8 +: 8];
  end

  assign sel_byte = lane_byte[addr_reg[1:0]];
  assign sel_half = addr_reg[1] ? ram_q[31:16] : ram_q[15:0];

  always_comb begin
    ext_data = ram_q;
    case (funct3_reg)
      3'b000:  ext_data = {{24{sel_byte[7]}}, sel_byte};
      3'b100:  ext_data = {24'd0, sel_byte};
      3'b001:  ext_data = {{16{sel_half[15]}}, sel_half};
      3'b101:  ext_data = {16'd0, sel_half};
      default: ext_data = ram_q;
    endcase
  end

  assign rsp_rdata = load_ok_reg ? ext_data : 32'd0;
  assign rsp_err   = err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with 1 wait state, one with 3 for the reset-abort case.
module tb_data_mem_responder;

`ifdef DMEM_STORE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst1, rst3;
  logic        req_valid1, req_valid3;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_ready;
  logic        req_ready1, rsp_valid1, rsp_err1;
  logic        req_ready3, rsp_valid3, rsp_err3;
  logic [31:0] rsp_rdata1, rsp_rdata3;

  logic        sel;
  logic        c_req_ready, c_rsp_valid, c_rsp_err;
  logic [31:0] c_rsp_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst1), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst3), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
  );

  assign c_req_ready = sel ? req_ready3 : req_ready1;
  assign c_rsp_valid = sel ? rsp_valid3 : rsp_valid1;
  assign c_rsp_err   = sel ? rsp_err3   : rsp_err1;
  assign c_rsp_rdata = sel ? rsp_rdata3 : rsp_rdata1;

  // Issues one request to the selected instance; lat counts clock edges from presentation to rsp_valid.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic got, output int lat,
                        output logic [31:0] rd, output logic er);
    @(negedge clk);
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    if (sel) req_valid3 = 1'b1; else req_valid1 = 1'b1;
    @(negedge clk);
    req_valid1 = 1'b0; req_valid3 = 1'b0;
    lat = 1;
    while (!c_rsp_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    got = c_rsp_valid;
    rd  = c_rsp_rdata;
    er  = c_rsp_err;
    if (got) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    $display("req sel=%0d we=%0d f3=%0d addr=%h wdata=%h -> got=%0d lat=%0d rdata=%h err=%0d",
             sel, we, f3, addr, wd, got, lat, rd, er);
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst3 = 1'b1;
    req_valid1 = 1'b0; req_valid3 = 1'b0; rsp_ready = 1'b0;
    req_we = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    sel = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (req_ready1 !== 1'b0) begin bad++; $display("FAIL reset_req_ready got=%b exp=0", req_ready1); end
    total++; if (rsp_valid1 !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid1); end
    total++; if (rsp_rdata1 !== 32'd0) begin bad++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata1); end
    total++; if (rsp_err1 !== 1'b0) begin bad++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err1); end
    rst1 = 1'b0; rst3 = 1'b0;
    #1;
    total++; if (req_ready1 !== 1'b1) begin bad++; $display("FAIL idle_req_ready got=%b exp=1", req_ready1); end
    $display("test_reset done");
  endtask

  task automatic test_word();
    logic got, er; int lat; logic [31:0] rd;
    sel = 1'b0;
    do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, got, lat, rd, er);
    total++; if (got !== ACK) begin bad++; $display("FAIL sw_ack got=%b exp=%b", got, ACK); end
    if (ACK) begin
      total++; if (er !== 1'b0 || rd !== 32'd0) begin bad++; $display("FAIL sw_rsp got=%h/%b exp=0/0", rd, er); end
    end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, got, lat, rd, er);
    total++; if (got !== 1'b1) begin bad++; $display("FAIL lw_got got=%b exp=1", got); end
    total++; if (lat != 2) begin bad++; $display("FAIL lw_latency got=%0d exp=2", lat); end
    total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL lw_err got=%b exp=0", er); end
    do_req(1'b1, 3'b010, 32'hFFC, 32'hCAFEF00D, got, lat, rd, er);
    do_req(1'b0, 3'b010, 32'hFFC, 32'h0, got, lat, rd, er);
    total++; if (rd !== 32'hCAFEF00D || er !== 1'b0) begin bad++; $display("FAIL lw_last_word got=%h/%b exp=cafef00d/0", rd, er); end
  endtask

  task automatic test_byte();
    logic got, er; int lat; logic [31:0] rd;
    sel = 1'b0;
    do_req(1'b1, 3'b000, 32'h13, 32'hAAAAAA80, got, lat, rd, er);
    do_req(1'b0, 3'b000, 32'h13, 32'h0, got, lat, rd, er);
    total++; if (rd !== 32'hFFFFFF80) begin bad++; $display("FAIL lb got=%h exp=ffffff80", rd); end
    do_req(1'b0, 3'b100, 32'h13, 32'h0, got, lat, rd, er);
    total++; if (rd !== 32'h00000080) begin bad++; $display("FAIL lbu got=%h exp=00000080", rd); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, got, lat, rd, er);
    total++; if (rd !== 32'h80ADBEEF) begin bad++; $display("FAIL lw_after_sb got=%h exp=80adbeef", rd); end
    do_req(1'b0, 3'b100, 32'h11, 32'h0, got, lat, rd, er);
    total++; if (rd !== 32'h000000BE) begin bad++; $display("FAIL lbu_lane1 got=%h exp=000000be", rd); end
  endtask

  task automatic test_half();
    logic got, er; int lat; logic [31:0] rd;
    sel = 1'b0;
    do_req(1'b1, 3'b010, 32'h14, 32'h11223344, got, lat, rd, er);
    do_req(1'b1, 3'b001, 32'h16, 32'hCAFE8001, got, lat, rd, er);
    do_req(1'b0, 3'b001, 32'h16, 32'h0, got, lat, rd, er);
    total++; if (rd !== 32'hFFFF8001) begin bad++; $display("FAIL lh_hi got=%h exp=ffff8001", rd); end
    do_req(1'b0, 3'b101, 32'h16, 32'h0, got, lat, rd, er);
    total++; if (rd !== 32'h00008001) begin bad++; $display("FAIL lhu_hi got=%h exp=00008001", rd); end
    do_req(1'b0, 3'b001, 32'h14, 32'h0, got, lat, rd, er);
    total++; if (rd !== 32'h00003344) begin bad++; $display("FAIL lh_lo got=%h exp=00003344", rd); end
    do_req(1'b0, 3'b010, 32'h14, 32'h0, got, lat, rd, er);
    total++; if (rd !== 32'h80013344) begin bad++; $display("FAIL lw_after_sh got=%h exp=80013344", rd); end
  endtask

  task automatic test_errors();
    logic got, er; int lat; logic [31:0] rd;
    sel = 1'b0;
    do_req(1'b0, 3'b001, 32'h11, 32'h0, got, lat, rd, er);
    total++; if (got !== 1'b1 || er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL lh_misaligned got=%b/%b/%h exp=1/1/0", got, er, rd); end
    total++; if (lat != 1) begin bad++; $display("FAIL err_latency got=%0d exp=1", lat); end
    do_req(1'b1, 3'b010, 32'h12, 32'h55555555, got, lat, rd, er);
    total++; if (got !== ACK) begin bad++; $display("FAIL sw_misaligned_ack got=%b exp=%b", got, ACK); end
    if (ACK) begin
      total++; if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL sw_misaligned_err got=%b/%h exp=1/0", er, rd); end
    end
    do_req(1'b1, 3'b100, 32'h10, 32'h66666666, got, lat, rd, er);
    do_req(1'b1, 3'b001, 32'h11, 32'h77777777, got, lat, rd, er);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, got, lat, rd, er);
    total++; if (rd !== 32'h80ADBEEF) begin bad++; $display("FAIL word_unchanged got=%h exp=80adbeef", rd); end
    do_req(1'b0, 3'b010, 32'h1000, 32'h0, got, lat, rd, er);
    total++; if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL lw_out_of_range got=%b/%h exp=1/0", er, rd); end
    do_req(1'b0, 3'b011, 32'h10, 32'h0, got, lat, rd, er);
    total++; if (er !== 1'b1 || rd !== 32'd0) begin bad++; $display("FAIL load_f3_011 got=%b/%h exp=1/0", er, rd); end
    do_req(1'b0, 3'b010, 32'h10, 32'h0, got, lat, rd, er);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=0", er); end
  endtask

  task automatic test_hold_resp();
    int n;
    sel = 1'b0;
    @(negedge clk);
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
    req_valid1 = 1'b1;
    @(negedge clk);
    req_valid1 = 1'b0;
    n = 0;
    while (!rsp_valid1 && n < 10) begin @(negedge clk); n++; end
    total++; if (rsp_valid1 !== 1'b1) begin bad++; $display("FAIL hold_timeout got=%b exp=1", rsp_valid1); end
    // A competing request during RESP must be ignored.
    req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h99999999; req_valid1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (rsp_valid1 !== 1'b1 || rsp_rdata1 !== 32'h80ADBEEF || req_ready1 !== 1'b0) begin
        bad++;
        $display("FAIL hold_stable cyc=%0d got=%b/%h/%b exp=1/80adbeef/0", i, rsp_valid1, rsp_rdata1, req_ready1);
      end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid1 = 1'b0;
    total++; if (rsp_valid1 !== 1'b0 || req_ready1 !== 1'b1) begin bad++; $display("FAIL hold_release got=%b/%b exp=0/1", rsp_valid1, req_ready1); end
    $display("test_hold_resp done");
  endtask

  task automatic test_back_to_back();
    logic got, er; int lat; logic [31:0] rd;
    sel = 1'b0;
    do_req(1'b0, 3'b010, 32'h10, 32'h0, got, lat, rd, er);
    total++; if (rd !== 32'h80ADBEEF) begin bad++; $display("FAIL held_req_ignored got=%h exp=80adbeef", rd); end
    do_req(1'b0, 3'b000, 32'h12, 32'h0, got, lat, rd, er);
    total++; if (rd !== 32'hFFFFFFAD) begin bad++; $display("FAIL b2b_lb got=%h exp=ffffffad", rd); end
  endtask

  task automatic test_wait3_reset();
    logic got, er; int lat; logic [31:0] rd;
    sel = 1'b1;
    do_req(1'b1, 3'b010, 32'h20, 32'hA5A5A5A5, got, lat, rd, er);
    do_req(1'b0, 3'b010, 32'h20, 32'h0, got, lat, rd, er);
    total++; if (lat != 4) begin bad++; $display("FAIL w3_latency got=%0d exp=4", lat); end
    total++; if (rd !== 32'hA5A5A5A5) begin bad++; $display("FAIL w3_lw got=%h exp=a5a5a5a5", rd); end
    @(negedge clk);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_valid3 = 1'b1;
    @(negedge clk);
    req_valid3 = 1'b0;
    @(negedge clk);
    rst3 = 1'b1;
    #1;
    total++; if (req_ready3 !== 1'b0) begin bad++; $display("FAIL w3_rst_req_ready got=%b exp=0", req_ready3); end
    @(negedge clk);
    rst3 = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (rsp_valid3 !== 1'b0) begin bad++; $display("FAIL w3_no_rsp got=%b exp=0", rsp_valid3); end
    do_req(1'b0, 3'b010, 32'h20, 32'h0, got, lat, rd, er);
    total++; if (rd !== 32'hA5A5A5A5) begin bad++; $display("FAIL w3_store_aborted got=%h exp=a5a5a5a5", rd); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_hold_resp();
    test_back_to_back();
    test_wait3_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
